// File: rtl/ypbpr_pkg.sv
// ----------------------------------------------------------------------------
// ypbpr_pkg
// Shared constants and helpers for the YPbPr colour-space path (decoder and
// encoder). Holds the fixed-point BT.601-style coefficients (x256 scale), the
// chroma offset, the rounding constant, the intermediate arithmetic width and
// the pipeline depth, plus the sync/mode bundle type carried alongside pixels.
// ----------------------------------------------------------------------------
package ypbpr_pkg;

   // Signed intermediate width; wide enough that no product or sum can wrap.
   localparam int IW         = 20;
   // Data and sync latency in clock cycles.
   localparam int PIPE_DEPTH = 3;

   // Colour-difference coefficients, scaled by 256.
   localparam logic signed [IW-1:0] COEF_R_CR = 20'sd359;
   localparam logic signed [IW-1:0] COEF_G_CB = 20'sd88;
   localparam logic signed [IW-1:0] COEF_G_CR = 20'sd183;
   localparam logic signed [IW-1:0] COEF_B_CB = 20'sd454;

   // Chroma zero level and round-half-up constant for the x256 sums.
   localparam logic [8:0]           CHROMA_OFS = 9'd128;
   localparam logic signed [IW-1:0] ROUND_C    = 20'sd128;

   // Timing bits that travel down the pipeline with each pixel.
   typedef struct packed {
      logic hsync;
      logic vsync;
      logic csync;
      logic de;
      logic ypbpr_en;
   } sync_bundle_t;

   // Remove the 128 chroma offset and sign-extend to the intermediate width.
   function automatic logic signed [IW-1:0] chroma_ext(input logic [7:0] c);
      logic signed [8:0] d;
      d = $signed({1'b0, c} - CHROMA_OFS);
      return {{(IW-9){d[8]}}, d};
   endfunction

   // Saturate a rounded x256 sum to an unsigned byte.
   function automatic logic [7:0] clamp_u8(input logic signed [IW-1:0] s);
      logic [7:0] r;
      if (s < 20'sd0) begin
         r = 8'd0;
      end else if (s >= 20'sd65536) begin
         r = 8'd255;
      end else begin
         r = s[15:8];
      end
      return r;
   endfunction

endpackage

// File: rtl/ypbpr_sync_delay.sv
// ----------------------------------------------------------------------------
// ypbpr_sync_delay
// Fixed 3-stage shift register for {hsync, vsync, csync, de, ypbpr_en}.
// Bits are only delayed, never modified. Asynchronous active-high reset
// clears every stage to 0.
// Ports:
//   clk     in   pixel clock
//   reset   in   asynchronous active-high reset
//   bits_i  in   bundle sampled this cycle
//   tap_o   out  bundle after two stages (aligned with the stage-3 input)
//   bits_o  out  bundle after three stages (aligned with the stage-3 output)
// ----------------------------------------------------------------------------
module ypbpr_sync_delay
   import ypbpr_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  sync_bundle_t bits_i,
   output sync_bundle_t tap_o,
   output sync_bundle_t bits_o
);

   sync_bundle_t [PIPE_DEPTH-1:0] stage_d;
   sync_bundle_t [PIPE_DEPTH-1:0] stage_q;

   // Next state: shift one position, new bundle enters at index 0.
   always_comb begin
      stage_d = {stage_q[PIPE_DEPTH-2:0], bits_i};
   end

   // Shift register with asynchronous clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stage_q <= '0;
      end else begin
         stage_q <= stage_d;
      end
   end

   assign tap_o  = stage_q[PIPE_DEPTH-2];
   assign bits_o = stage_q[PIPE_DEPTH-1];

endmodule

// File: rtl/ypbpr_decode.sv
// ----------------------------------------------------------------------------
// ypbpr_decode
// Pipelined YPbPr -> RGB decoder with saturation and per-pixel bypass.
//   Stage 1: offset-corrected chroma products and Y*256.
//   Stage 2: rounded x256 sums.
//   Stage 3: clamped bytes (decode) or the raw word (bypass).
// Data and hsync/vsync/csync/de all leave exactly 3 cycles after entry.
// Ports:
//   clk, reset            pixel clock, asynchronous active-high reset
//   ypbpr_en              1 = decode din, 0 = pass din through (per pixel)
//   hsync/vsync/csync/de  timing inputs, delayed verbatim
//   din[23:0]             {Pr, Y, Pb} in decode mode, {R, G, B} in bypass
//   dout[23:0]            {R, G, B}
//   hsync_o..de_o         timing outputs aligned with dout
// Build option:
//   YPBPR_DEC_BLANK_EN    when defined, dout is forced to 0 on every cycle
//                         where the delayed de is 0 (both modes).
// ----------------------------------------------------------------------------
module ypbpr_decode
   import ypbpr_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        ypbpr_en,
   input  logic        hsync,
   input  logic        vsync,
   input  logic        csync,
   input  logic        de,
   input  logic [23:0] din,
   output logic [23:0] dout,
   output logic        hsync_o,
   output logic        vsync_o,
   output logic        csync_o,
   output logic        de_o
);

`ifdef YPBPR_DEC_BLANK_EN
   localparam logic BLANK_EN = 1'b1;
`else
   localparam logic BLANK_EN = 1'b0;
`endif

   // Stage 1
   logic signed [IW-1:0] y_d, y_q;
   logic signed [IW-1:0] r_cr_d, r_cr_q;
   logic signed [IW-1:0] g_cb_d, g_cb_q;
   logic signed [IW-1:0] g_cr_d, g_cr_q;
   logic signed [IW-1:0] b_cb_d, b_cb_q;
   logic [23:0]          raw1_d, raw1_q;
   // Stage 2
   logic signed [IW-1:0] r_sum_d, r_sum_q;
   logic signed [IW-1:0] g_sum_d, g_sum_q;
   logic signed [IW-1:0] b_sum_d, b_sum_q;
   logic [23:0]          raw2_d, raw2_q;
   // Stage 3
   logic [23:0]          pix_s;
   logic [23:0]          dout_d, dout_q;

   logic signed [IW-1:0] cb_s, cr_s;
   sync_bundle_t         sync_in_s, sync_tap_s, sync_out_s;
   logic                 sync_unused_s;

   // Pack the timing and mode bits that ride along with the pixel.
   always_comb begin
      sync_in_s.hsync    = hsync;
      sync_in_s.vsync    = vsync;
      sync_in_s.csync    = csync;
      sync_in_s.de       = de;
      sync_in_s.ypbpr_en = ypbpr_en;
   end

   ypbpr_sync_delay u_sync_delay (
      .clk    (clk),
      .reset  (reset),
      .bits_i (sync_in_s),
      .tap_o  (sync_tap_s),
      .bits_o (sync_out_s)
   );

   // Stage-1 next state: chroma offsets and coefficient products.
   always_comb begin
      cb_s   = chroma_ext(din[7:0]);
      cr_s   = chroma_ext(din[23:16]);
      y_d    = {4'd0, din[15:8], 8'd0};
      r_cr_d = cr_s * COEF_R_CR;
      g_cb_d = cb_s * COEF_G_CB;
      g_cr_d = cr_s * COEF_G_CR;
      b_cb_d = cb_s * COEF_B_CB;
      raw1_d = din;
   end

   // Stage-2 next state: rounded sums, bypass word carried alongside.
   always_comb begin
      r_sum_d = y_q + r_cr_q + ROUND_C;
      g_sum_d = y_q - g_cb_q - g_cr_q + ROUND_C;
      b_sum_d = y_q + b_cb_q + ROUND_C;
      raw2_d  = raw1_q;
   end

   // Stage-3 next state: mode select uses the mode bit travelling with this
   // pixel (two-stage tap), so toggling ypbpr_en never mixes neighbours.
   always_comb begin
      if (sync_tap_s.ypbpr_en) begin
         pix_s = {clamp_u8(r_sum_q), clamp_u8(g_sum_q), clamp_u8(b_sum_q)};
      end else begin
         pix_s = raw2_q;
      end
      if (BLANK_EN && !sync_tap_s.de) begin
         dout_d = 24'h000000;
      end else begin
         dout_d = pix_s;
      end
   end

   // Data pipeline registers, all cleared asynchronously.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         y_q     <= '0;
         r_cr_q  <= '0;
         g_cb_q  <= '0;
         g_cr_q  <= '0;
         b_cb_q  <= '0;
         raw1_q  <= '0;
         r_sum_q <= '0;
         g_sum_q <= '0;
         b_sum_q <= '0;
         raw2_q  <= '0;
         dout_q  <= '0;
      end else begin
         y_q     <= y_d;
         r_cr_q  <= r_cr_d;
         g_cb_q  <= g_cb_d;
         g_cr_q  <= g_cr_d;
         b_cb_q  <= b_cb_d;
         raw1_q  <= raw1_d;
         r_sum_q <= r_sum_d;
         g_sum_q <= g_sum_d;
         b_sum_q <= b_sum_d;
         raw2_q  <= raw2_d;
         dout_q  <= dout_d;
      end
   end

   // Tap bits with no consumer here: the stage-3 mode bit (the mux decides one
   // stage earlier) and the early sync copies.
   assign sync_unused_s = ^{sync_out_s.ypbpr_en, sync_tap_s.hsync,
                            sync_tap_s.vsync, sync_tap_s.csync};

   assign dout    = dout_q;
   assign hsync_o = sync_out_s.hsync;
   assign vsync_o = sync_out_s.vsync;
   assign csync_o = sync_out_s.csync;
   assign de_o    = sync_out_s.de;

endmodule

// File: tb/tb_ypbpr_decode.sv
// ----------------------------------------------------------------------------
// tb_ypbpr_decode
// Directed self-checking bench for ypbpr_decode. Inputs change on the falling
// edge; outputs are sampled on the falling edge, three rising edges after the
// pixel was applied. Expected values are hand-computed from the x256 formulas.
// ----------------------------------------------------------------------------
module tb_ypbpr_decode;

`ifdef YPBPR_DEC_BLANK_EN
   localparam bit BLANK = 1'b1;
`else
   localparam bit BLANK = 1'b0;
`endif

   localparam int N_VEC = 15;

   typedef struct packed {
      logic [23:0] din;
      logic        en;
      logic [3:0]  sy;   // {hsync, vsync, csync, de}
      logic [23:0] exp;  // expected dout before blanking
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        ypbpr_en, hsync, vsync, csync, de;
   logic [23:0] din, dout;
   logic        hsync_o, vsync_o, csync_o, de_o;

   int n_tests = 0;
   int n_fail  = 0;
   vec_t vecs [N_VEC];

   ypbpr_decode dut (
      .clk      (clk),
      .reset    (reset),
      .ypbpr_en (ypbpr_en),
      .hsync    (hsync),
      .vsync    (vsync),
      .csync    (csync),
      .de       (de),
      .din      (din),
      .dout     (dout),
      .hsync_o  (hsync_o),
      .vsync_o  (vsync_o),
      .csync_o  (csync_o),
      .de_o     (de_o)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [23:0] got, input logic [23:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [23:0] d, input logic en, input logic [3:0] s);
      din      = d;
      ypbpr_en = en;
      {hsync, vsync, csync, de} = s;
   endtask

   function automatic logic [23:0] blanked(input logic [23:0] v, input logic de_v);
      return (BLANK && !de_v) ? 24'h000000 : v;
   endfunction

   function automatic logic [23:0] sync_word();
      return {20'h00000, hsync_o, vsync_o, csync_o, de_o};
   endfunction

   initial begin
      //           din          en    {h,v,c,de} expected
      vecs[0]  = {24'h808080, 1'b1, 4'b0001, 24'h808080}; // neutral grey
      vecs[1]  = {24'h80FF80, 1'b1, 4'b0001, 24'hFFFFFF}; // white
      vecs[2]  = {24'hFF0080, 1'b1, 4'b0001, 24'hB20000}; // G negative clamp
      vecs[3]  = {24'hFFFF80, 1'b1, 4'b0001, 24'hFFA4FF}; // R overflow clamp
      vecs[4]  = {24'hFF4C56, 1'b1, 4'b0001, 24'hFE0002}; // pure red loopback
      vecs[5]  = {24'h123456, 1'b0, 4'b0001, 24'h123456}; // bypass
      vecs[6]  = {24'h808080, 1'b1, 4'b0000, 24'h808080}; // de low
      vecs[7]  = {24'h808080, 1'b0, 4'b1001, 24'h808080}; // hsync pulse
      vecs[8]  = {24'h123456, 1'b1, 4'b0101, 24'h009100}; // vsync pulse, decode
      vecs[9]  = {24'h123456, 1'b0, 4'b0011, 24'h123456}; // csync pulse, bypass
      vecs[10] = {24'h123456, 1'b1, 4'b0000, 24'h009100};
      vecs[11] = {24'h123456, 1'b0, 4'b0001, 24'h123456}; // de pulse + mode flip
      vecs[12] = {24'h808080, 1'b1, 4'b0000, 24'h808080};
      vecs[13] = {24'hC86432, 1'b1, 4'b0001, 24'hC94B00}; // mixed, B clamps low
      vecs[14] = {24'h80C8FF, 1'b1, 4'b0001, 24'hC89CFF}; // B overflow clamp

      reset = 1'b1;
      drive(24'h000000, 1'b0, 4'b0000);
      repeat (2) @(negedge clk);
      check_eq("reset_dout", dout, 24'h000000);
      check_eq("reset_sync", sync_word(), 24'h000000);
      reset = 1'b0;

      // Stream the vector table back to back; check each pixel 3 cycles later.
      for (int i = 0; i < N_VEC + 3; i++) begin
         if (i < 3) begin
            check_eq($sformatf("flush_dout[%0d]", i), dout, 24'h000000);
         end else begin
            check_eq($sformatf("dout[%0d]", i - 3), dout,
                     blanked(vecs[i-3].exp, vecs[i-3].sy[0]));
            check_eq($sformatf("sync[%0d]", i - 3), sync_word(),
                     {20'h00000, vecs[i-3].sy});
         end
         if (i < N_VEC) begin
            drive(vecs[i].din, vecs[i].en, vecs[i].sy);
         end else begin
            drive(24'h000000, 1'b0, 4'b0000);
         end
         @(negedge clk);
      end

      // Mid-stream reset: fill with white, then reset between edges.
      drive(24'h80FF80, 1'b1, 4'b1111);
      repeat (3) @(negedge clk);
      check_eq("pre_reset_dout", dout, 24'hFFFFFF);
      check_eq("pre_reset_sync", sync_word(), 24'h00000F);
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check_eq("async_reset_dout", dout, 24'h000000);
      check_eq("async_reset_sync", sync_word(), 24'h000000);

      drive(24'hFF4C56, 1'b1, 4'b1111);
      @(negedge clk);
      check_eq("held_reset_dout", dout, 24'h000000);
      reset = 1'b0;
      @(negedge clk);
      drive(24'h000000, 1'b0, 4'b0000);
      check_eq("post_reset_z1_dout", dout, 24'h000000);
      check_eq("post_reset_z1_sync", sync_word(), 24'h000000);
      @(negedge clk);
      check_eq("post_reset_z2_dout", dout, 24'h000000);
      check_eq("post_reset_z2_sync", sync_word(), 24'h000000);
      @(negedge clk);
      check_eq("post_reset_first_dout", dout, 24'hFE0002);
      check_eq("post_reset_first_sync", sync_word(), 24'h00000F);
      @(negedge clk);
      check_eq("post_reset_idle_dout", dout, 24'h000000);
      check_eq("post_reset_idle_sync", sync_word(), 24'h000000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
